// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU control/datapath front end.
package hack_pkg;

  localparam int HACK_W    = 16;
  localparam int HACK_PC_W = 15;

  // Instruction-word field positions
  localparam int A_BIT    = 12;
  localparam int CTRL_LSB = 6;
  localparam int DEST_LSB = 3;
  localparam int JMP_LSB  = 0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_WR = 3'd4
  } state_e;

endpackage

// File: rtl/hack_jump_cond.sv
// Combinational jump decision from the three jump bits and the ALU result.
module hack_jump_cond
  import hack_pkg::*;
#(
  parameter int W = HACK_W
) (
  input  logic [2:0]   jbits_i,
  input  logic [W-1:0] alu_out_i,
  output logic         take_o
);

  logic ng_s;
  logic zr_s;

  // Sign/zero flags and jump selection
  always_comb begin
    ng_s   = alu_out_i[W-1];
    zr_s   = (alu_out_i == {W{1'b0}});
    take_o = (jbits_i[2] & ng_s) | (jbits_i[1] & zr_s) | (jbits_i[0] & ~ng_s & ~zr_s);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU multi-cycle control/datapath front end (fetch, A/D/PC, M access, jumps).
// Optional HACK_INSTRET_EN adds a 32-bit retired-instruction counter on INSTRET.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int              W        = HACK_W,
  parameter int              PC_W     = HACK_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [W-1:0]    IMEM_DATA,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [PC_W-1:0] DMEM_ADDR,
  output logic [W-1:0]    DMEM_WDATA,
  input  logic            DMEM_ACK,
  input  logic [W-1:0]    DMEM_RDATA,
  output logic [W-1:0]    ALU_X,
  output logic [W-1:0]    ALU_Y,
  output logic            ZX,
  output logic            NX,
  output logic            ZY,
  output logic            NY,
  output logic            F,
  output logic            NO,
  input  logic [W-1:0]    ALU_OUT
`ifdef HACK_INSTRET_EN
  ,
  output logic [31:0]     INSTRET
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] a_old_q, a_old_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    ir_q, ir_d;
  logic [W-1:0]    mdr_q, mdr_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic            retire_s;
  logic            take_s;
  logic [PC_W-1:0] pc_inc_s;

  hack_jump_cond #(.W(W)) u_jump_cond (
    .jbits_i   (ir_q[JMP_LSB +: 3]),
    .alu_out_i (ALU_OUT),
    .take_o    (take_s)
  );

  assign pc_inc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  // Next-state, datapath updates and request strobes
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_old_d  = a_old_q;
    a_d      = a_q;
    d_d      = d_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    wdata_d  = wdata_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        a_old_d = a_q[PC_W-1:0];
        if (!ir_q[W-1]) begin
          a_d      = {{(W-PC_W){1'b0}}, ir_q[PC_W-1:0]};
          pc_d     = pc_inc_s;
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else if (ir_q[A_BIT]) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM_RD: begin
        if (dmem_req_q && DMEM_ACK) begin
          mdr_d   = DMEM_RDATA;
          state_d = S_EXEC;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_EXEC: begin
        if (ir_q[DEST_LSB+2]) begin
          a_d = ALU_OUT;
        end else begin
          a_d = a_q;
        end
        if (ir_q[DEST_LSB+1]) begin
          d_d = ALU_OUT;
        end else begin
          d_d = d_q;
        end
        // Jump target is the A value from instruction start, even if A is rewritten here
        pc_d = take_s ? a_old_q : pc_inc_s;
        if (ir_q[DEST_LSB]) begin
          wdata_d = ALU_OUT;
          state_d = S_MEM_WR;
        end else begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_MEM_WR: begin
        if (dmem_req_q && DMEM_ACK) begin
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_MEM_WR;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    dmem_we_d  = (state_d == S_MEM_WR);
  end

  // State, architectural registers and registered request outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      a_old_q    <= {PC_W{1'b0}};
      a_q        <= {W{1'b0}};
      d_q        <= {W{1'b0}};
      ir_q       <= {W{1'b0}};
      mdr_q      <= {W{1'b0}};
      wdata_q    <= {W{1'b0}};
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      a_old_q    <= a_old_d;
      a_q        <= a_d;
      d_q        <= d_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      wdata_q    <= wdata_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  assign IMEM_REQ   = imem_req_q;
  assign IMEM_ADDR  = pc_q;
  assign DMEM_REQ   = dmem_req_q;
  assign DMEM_WE    = dmem_we_q;
  assign DMEM_ADDR  = a_old_q;
  assign DMEM_WDATA = wdata_q;
  assign ALU_X      = d_q;
  assign ALU_Y      = ir_q[A_BIT] ? mdr_q : a_q;
  assign ZX         = ir_q[CTRL_LSB+5];
  assign NX         = ir_q[CTRL_LSB+4];
  assign ZY         = ir_q[CTRL_LSB+3];
  assign NY         = ir_q[CTRL_LSB+2];
  assign F          = ir_q[CTRL_LSB+1];
  assign NO         = ir_q[CTRL_LSB];

`ifdef HACK_INSTRET_EN
  logic [31:0] instret_q;

  // Retired-instruction counter, wraps at 2^32
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instret_q <= 32'd0;
    end else if (retire_s) begin
      instret_q <= instret_q + 32'd1;
    end else begin
      instret_q <= instret_q;
    end
  end

  assign INSTRET = instret_q;
`else
  logic unused_retire_s;
  assign unused_retire_s = retire_s;
`endif

endmodule
